// File: rtl/spi_frame_guard.sv
`default_nettype none
// ============================================================================
//  Module   : spi_frame_guard
//  Purpose  : Checksums SPI frames byte-serially, publishes good payloads,
//             runs a link watchdog and builds the tx_data return word.
//  Revision : 1.0 - initial release
// ============================================================================
module spi_frame_guard #(
    parameter int          BUFFER_SIZE_RX = 64,
    parameter int          BUFFER_SIZE_TX = 64,
    parameter logic [31:0] MSGID          = 32'h74697277,
    parameter logic [31:0] TIMEOUT        = 32'd5000000
) (
    input  logic                        clk,
    input  logic                        rst,
    input  logic [BUFFER_SIZE_RX-1:0]   rx_data,
    input  logic                        sync,
    input  logic [BUFFER_SIZE_TX-41:0]  tx_payload,
    output logic [BUFFER_SIZE_TX-1:0]   tx_data,
    output logic [BUFFER_SIZE_RX-41:0]  data_out,
    output logic                        valid,
    output logic                        enable,
    output logic [7:0]                  err_cnt
);

    localparam int                 c_NB       = BUFFER_SIZE_RX / 8;
    localparam int                 c_IDX_W    = $clog2(c_NB);
    localparam logic [c_IDX_W-1:0] c_LAST_IDX = c_IDX_W'(c_NB - 2);
    localparam logic [31:0]        c_WD_MAX   = TIMEOUT - 32'd1;
    localparam logic [31:0]        c_WD_WARN  = TIMEOUT - 32'd2;

    localparam logic [1:0] c_ST_IDLE   = 2'd0;
    localparam logic [1:0] c_ST_CHECK  = 2'd1;
    localparam logic [1:0] c_ST_COMMIT = 2'd2;

    logic [1:0]                r_state;
    logic [1:0]                w_next_state;
    logic [BUFFER_SIZE_RX-1:0] r_shadow;
    logic [7:0]                r_acc;
    logic [c_IDX_W-1:0]        r_idx;
    logic [7:0]                w_byte;
    logic                      w_good;
    logic                      w_bad;
    logic                      w_timeout;
    logic [31:0]               r_wdog;
    logic [5:0]                r_good_cnt;
    logic                      r_bad_flag;
    logic                      r_valid;
    logic                      r_enable;
    logic [BUFFER_SIZE_RX-41:0] r_data_out;
    logic [7:0]                r_err_cnt;
    logic [BUFFER_SIZE_TX-1:0] r_tx_data;

    always_ff @(posedge clk) begin
        if (rst) r_state <= c_ST_IDLE;
        else     r_state <= w_next_state;
    end

    // A sync strobe restarts the check from any state, including COMMIT
    always_comb begin
        w_next_state = c_ST_IDLE;
        case (r_state)
            c_ST_IDLE:   w_next_state = c_ST_IDLE;
            c_ST_CHECK:  w_next_state = (r_idx == c_LAST_IDX) ? c_ST_COMMIT : c_ST_CHECK;
            c_ST_COMMIT: w_next_state = c_ST_IDLE;
            default:     w_next_state = c_ST_IDLE;
        endcase
        if (sync) w_next_state = c_ST_CHECK;
    end

    always_comb begin
        w_good    = (r_state == c_ST_COMMIT) && (r_acc == r_shadow[7:0]);
        w_bad     = (r_state == c_ST_COMMIT) && (r_acc != r_shadow[7:0]);
        w_timeout = (r_wdog >= c_WD_WARN);
    end

    always_comb begin
        w_byte = 8'h00;
        for (int i = 0; i < c_NB - 1; i++) begin
            if (r_idx == c_IDX_W'(i)) w_byte = r_shadow[BUFFER_SIZE_RX-1-8*i -: 8];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_shadow <= '0;
            r_acc    <= 8'h00;
            r_idx    <= '0;
        end else if (sync) begin
            r_shadow <= rx_data;
            r_acc    <= 8'h00;
            r_idx    <= '0;
        end else if (r_state == c_ST_CHECK) begin
            r_acc <= r_acc + w_byte;
            r_idx <= r_idx + 1'b1;
        end
    end

    // Enable drops on the same edge the watchdog lands on its ceiling
    always_ff @(posedge clk) begin
        if (rst) begin
            r_valid    <= 1'b0;
            r_enable   <= 1'b0;
            r_data_out <= '0;
            r_err_cnt  <= 8'h00;
            r_good_cnt <= 6'd0;
            r_bad_flag <= 1'b0;
            r_wdog     <= 32'd0;
        end else begin
            r_valid <= w_good;
            if (w_good) begin
                r_data_out <= r_shadow[BUFFER_SIZE_RX-33:8];
                r_enable   <= 1'b1;
                r_wdog     <= 32'd0;
                r_good_cnt <= r_good_cnt + 6'd1;
                r_bad_flag <= 1'b0;
            end else begin
                if (r_wdog != c_WD_MAX) r_wdog <= r_wdog + 32'd1;
                if (w_timeout) begin
                    r_enable   <= 1'b0;
                    r_data_out <= '0;
                end
                if (w_bad) begin
                    if (r_err_cnt != 8'hFF) r_err_cnt <= r_err_cnt + 8'h01;
                    r_bad_flag <= 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) r_tx_data <= {MSGID, 8'h00, {(BUFFER_SIZE_TX-40){1'b0}}};
        else     r_tx_data <= {MSGID, r_enable, r_bad_flag, r_good_cnt, tx_payload};
    end

    assign tx_data  = r_tx_data;
    assign data_out = r_data_out;
    assign valid    = r_valid;
    assign enable   = r_enable;
    assign err_cnt  = r_err_cnt;

endmodule
`default_nettype wire

// File: tb/tb_spi_frame_guard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_spi_frame_guard
//  Purpose  : Directed self-checking bench for spi_frame_guard (N=64, TIMEOUT=16).
//  Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_spi_frame_guard;

    localparam logic [31:0] c_MSG = 32'h74697277;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        sync = 1'b0;
    logic [63:0] rx_data = 64'h0;
    logic [23:0] tx_payload = 24'h123456;
    logic [63:0] tx_data;
    logic [23:0] data_out;
    logic        valid;
    logic        enable;
    logic [7:0]  err_cnt;

    int n_pass  = 0;
    int n_total = 0;

    always #5 clk = ~clk;

    spi_frame_guard #(
        .BUFFER_SIZE_RX (64),
        .BUFFER_SIZE_TX (64),
        .MSGID          (32'h74697277),
        .TIMEOUT        (32'd16)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .rx_data    (rx_data),
        .sync       (sync),
        .tx_payload (tx_payload),
        .tx_data    (tx_data),
        .data_out   (data_out),
        .valid      (valid),
        .enable     (enable),
        .err_cnt    (err_cnt)
    );

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic send(input logic [63:0] f);
        rx_data = f;
        sync    = 1'b1;
        step(1);
        sync    = 1'b0;
    endtask

    // Header bytes 74+69+72+77 sum to 8'hC6
    function automatic logic [63:0] frame(input logic [23:0] p, input logic good);
        logic [7:0] s;
        s = 8'hC6 + p[23:16] + p[15:8] + p[7:0];
        if (!good) s = s + 8'h01;
        return {c_MSG, p, s};
    endfunction

    task automatic test_reset();
        rst = 1'b1;
        step(2);
        n_total++; if (valid !== 1'b0) $display("FAIL reset_valid: got %b expected 0", valid); else n_pass++;
        n_total++; if (enable !== 1'b0) $display("FAIL reset_enable: got %b expected 0", enable); else n_pass++;
        n_total++; if (data_out !== 24'h0) $display("FAIL reset_data_out: got %h expected 000000", data_out); else n_pass++;
        n_total++; if (err_cnt !== 8'h00) $display("FAIL reset_err_cnt: got %h expected 00", err_cnt); else n_pass++;
        n_total++; if (tx_data !== {c_MSG, 8'h00, 24'h000000}) $display("FAIL reset_tx_data: got %h expected %h", tx_data, {c_MSG, 8'h00, 24'h000000}); else n_pass++;
        rst = 1'b0;
        step(1);
        n_total++; if (tx_data !== {c_MSG, 8'h00, 24'h123456}) $display("FAIL tx_after_reset: got %h expected %h", tx_data, {c_MSG, 8'h00, 24'h123456}); else n_pass++;
    endtask

    task automatic test_good_frame();
        int cnt = 0;
        int first = 0;
        send(64'h74697277_010203CC);
        for (int i = 1; i <= 8; i++) begin
            step(1);
            if (valid === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        n_total++; if (cnt !== 1) $display("FAIL good_valid_count: got %0d expected 1", cnt); else n_pass++;
        n_total++; if (first !== 8) $display("FAIL good_valid_latency: got %0d expected 8", first); else n_pass++;
        n_total++; if (data_out !== 24'h010203) $display("FAIL good_data_out: got %h expected 010203", data_out); else n_pass++;
        n_total++; if (enable !== 1'b1) $display("FAIL good_enable: got %b expected 1", enable); else n_pass++;
        step(1);
        n_total++; if (tx_data[31:24] !== 8'h81) $display("FAIL good_status: got %h expected 81", tx_data[31:24]); else n_pass++;
        n_total++; if (valid !== 1'b0) $display("FAIL good_valid_width: got %b expected 0", valid); else n_pass++;
    endtask

    task automatic test_bad_checksum();
        send(64'h74697277_010203CD);
        step(8);
        n_total++; if (valid !== 1'b0) $display("FAIL bad_valid: got %b expected 0", valid); else n_pass++;
        n_total++; if (err_cnt !== 8'd1) $display("FAIL bad_err_cnt: got %0d expected 1", err_cnt); else n_pass++;
        n_total++; if (data_out !== 24'h010203) $display("FAIL bad_data_out: got %h expected 010203", data_out); else n_pass++;
        step(1);
        n_total++; if (tx_data[31:24] !== 8'hC1) $display("FAIL bad_status: got %h expected C1", tx_data[31:24]); else n_pass++;
        send(64'h74697277_010203CC);
        step(8);
        n_total++; if (valid !== 1'b1) $display("FAIL recover_valid: got %b expected 1", valid); else n_pass++;
        step(1);
        n_total++; if (tx_data[31:24] !== 8'h82) $display("FAIL recover_status: got %h expected 82", tx_data[31:24]); else n_pass++;
    endtask

    task automatic test_abort();
        int cnt = 0;
        int first = 0;
        send(frame(24'h010203, 1'b1));
        step(2);
        send(64'h74697277_AABBCCF7);
        for (int i = 1; i <= 12; i++) begin
            step(1);
            if (valid === 1'b1) begin
                cnt++;
                if (first == 0) first = i;
            end
        end
        n_total++; if (cnt !== 1) $display("FAIL abort_valid_count: got %0d expected 1", cnt); else n_pass++;
        n_total++; if (first !== 8) $display("FAIL abort_valid_latency: got %0d expected 8", first); else n_pass++;
        n_total++; if (data_out !== 24'hAABBCC) $display("FAIL abort_data_out: got %h expected AABBCC", data_out); else n_pass++;
        n_total++; if (err_cnt !== 8'd1) $display("FAIL abort_err_cnt: got %0d expected 1", err_cnt); else n_pass++;
    endtask

    task automatic test_back_to_back();
        send(frame(24'h5A5A5A, 1'b1));
        step(7);
        send(frame(24'h0F1E2D, 1'b1));
        n_total++; if (valid !== 1'b1) $display("FAIL b2b_first_valid: got %b expected 1", valid); else n_pass++;
        n_total++; if (data_out !== 24'h5A5A5A) $display("FAIL b2b_first_data: got %h expected 5A5A5A", data_out); else n_pass++;
        step(1);
        n_total++; if (valid !== 1'b0) $display("FAIL b2b_gap_valid: got %b expected 0", valid); else n_pass++;
        step(7);
        n_total++; if (valid !== 1'b1) $display("FAIL b2b_second_valid: got %b expected 1", valid); else n_pass++;
        n_total++; if (data_out !== 24'h0F1E2D) $display("FAIL b2b_second_data: got %h expected 0F1E2D", data_out); else n_pass++;
    endtask

    task automatic test_watchdog();
        send(frame(24'h3C3C3C, 1'b1));
        step(8);
        n_total++; if (valid !== 1'b1) $display("FAIL wd_commit_valid: got %b expected 1", valid); else n_pass++;
        step(14);
        n_total++; if (enable !== 1'b1) $display("FAIL wd_enable_before: got %b expected 1", enable); else n_pass++;
        step(1);
        n_total++; if (enable !== 1'b0) $display("FAIL wd_enable_after: got %b expected 0", enable); else n_pass++;
        n_total++; if (data_out !== 24'h0) $display("FAIL wd_data_out: got %h expected 000000", data_out); else n_pass++;
        send(frame(24'h102030, 1'b1));
        step(8);
        n_total++; if (enable !== 1'b1) $display("FAIL wd_restore_enable: got %b expected 1", enable); else n_pass++;
        n_total++; if (data_out !== 24'h102030) $display("FAIL wd_restore_data: got %h expected 102030", data_out); else n_pass++;
    endtask

    task automatic test_saturation();
        rst = 1'b1;
        step(1);
        rst = 1'b0;
        for (int i = 0; i < 254; i++) begin
            send(frame(24'(i), 1'b0));
            step(8);
        end
        n_total++; if (err_cnt !== 8'd254) $display("FAIL err_cnt_254: got %0d expected 254", err_cnt); else n_pass++;
        for (int i = 254; i < 300; i++) begin
            send(frame(24'(i), 1'b0));
            step(8);
        end
        n_total++; if (err_cnt !== 8'd255) $display("FAIL err_cnt_sat: got %0d expected 255", err_cnt); else n_pass++;
        for (int i = 0; i < 64; i++) begin
            send(frame(24'(i * 3), 1'b1));
            step(8);
        end
        step(1);
        n_total++; if (tx_data[31:24] !== 8'h80) $display("FAIL good_cnt_wrap: got %h expected 80", tx_data[31:24]); else n_pass++;
        send(frame(24'h445566, 1'b1));
        step(9);
        n_total++; if (tx_data[31:24] !== 8'h81) $display("FAIL good_cnt_65: got %h expected 81", tx_data[31:24]); else n_pass++;
        n_total++; if (err_cnt !== 8'd255) $display("FAIL err_cnt_hold: got %0d expected 255", err_cnt); else n_pass++;
    endtask

    task automatic test_reset_mid_check();
        int cnt = 0;
        send(frame(24'h777777, 1'b1));
        step(1);
        rst = 1'b1;
        step(1);
        n_total++; if (valid !== 1'b0) $display("FAIL midrst_valid: got %b expected 0", valid); else n_pass++;
        n_total++; if (enable !== 1'b0) $display("FAIL midrst_enable: got %b expected 0", enable); else n_pass++;
        n_total++; if (data_out !== 24'h0) $display("FAIL midrst_data_out: got %h expected 000000", data_out); else n_pass++;
        n_total++; if (err_cnt !== 8'h00) $display("FAIL midrst_err_cnt: got %h expected 00", err_cnt); else n_pass++;
        n_total++; if (tx_data !== {c_MSG, 8'h00, 24'h000000}) $display("FAIL midrst_tx_data: got %h expected %h", tx_data, {c_MSG, 8'h00, 24'h000000}); else n_pass++;
        rst = 1'b0;
        for (int i = 0; i < 10; i++) begin
            step(1);
            if (valid === 1'b1) cnt++;
        end
        n_total++; if (cnt !== 0) $display("FAIL midrst_no_valid: got %0d expected 0", cnt); else n_pass++;
    endtask

    initial begin
        test_reset();
        test_good_frame();
        test_bad_checksum();
        test_abort();
        test_back_to_back();
        test_watchdog();
        test_saturation();
        test_reset_mid_check();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

    initial begin
        #1000000;
        $display("FAIL global_timeout: got no finish expected finish by 1000000ns");
        $fatal(1, "bench time limit reached");
    end

endmodule
`default_nettype wire
